muldiv_seq: RTL

Iterative multiply/divide unit for the execute stage. It replaces the single-cycle combinational multiplier with a WIDTH-parametrised, one-bit-per-cycle engine. The engine covers signed and unsigned multiply and divide, and produces a double-width {hi, lo} result for the HI/LO write path. The execute stage holds the pipeline while `busy_o` is high, and consumes `hi_o`/`lo_o` in the cycle `ready_o` pulses.

---
 rtl/muldiv_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative one-bit-per-cycle multiply/divide unit producing a double-width {hi, lo} result.
// Shift-add multiply and restoring divide share one accumulator/shift-register pair.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div0_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    op_t              op;
    logic             sa, sb;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;   // multiplicand or divisor
    logic [WIDTH-1:0] acc;    // product high half or partial remainder
    logic [WIDTH-1:0] low;    // multiplier shifting out / quotient shifting in

    // Operand capture: signed ops work on magnitudes and fix the sign at the end.
    logic             req, req_div, div_zero, last;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign req      = start_i && !annul_i;
    assign req_div  = op_i[1];
    assign div_zero = req_div && (opb_i == '0);
    assign abs_a    = (op_i[0] && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    assign abs_b    = (op_i[0] && opb_i[WIDTH-1]) ? -opb_i : opb_i;
    assign last     = (state == RUN) && !annul_i && (cnt == CW'(1));

    // One iteration of both algorithms; op selects which result is kept.
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   step_acc, step_low;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mul_sum  = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc, low[WIDTH-1]};
        div_diff = {1'b0, div_sh} - {2'b00, opnd};
        div_ok   = !div_diff[WIDTH+1];
        step_acc = mul_sum[WIDTH:1];
        step_low = {mul_sum[0], low[WIDTH-1:1]};
        if (op[1]) begin
            step_acc = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_low = {low[WIDTH-2:0], div_ok};
        end
        prod_fix = {step_acc, step_low};
        if (op == OP_MULT && sa != sb) prod_fix = -{step_acc, step_low};
        quot_fix = (op == OP_DIV && sa != sb) ? -step_low : step_low;
        rem_fix  = (op == OP_DIV && sa) ? -step_acc : step_acc;
        res_hi   = op[1] ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = op[1] ? quot_fix : prod_fix[WIDTH-1:0];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req) state_nx = div_zero ? DONE : RUN;
            RUN:     if (annul_i) state_nx = IDLE;
                     else if (cnt == CW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
        end else begin
            state   <= state_nx;
            busy_o  <= (state_nx == RUN);
            ready_o <= (state_nx == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= OP_MULTU;
            sa     <= 1'b0;
            sb     <= 1'b0;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            low    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
            div0_o <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                op   <= op_t'(op_i);
                sa   <= op_i[0] && opa_i[WIDTH-1];
                sb   <= op_i[0] && opb_i[WIDTH-1];
                cnt  <= CW'(WIDTH);
                acc  <= '0;
                opnd <= req_div ? abs_b : abs_a;
                low  <= req_div ? abs_a : abs_b;
                if (div_zero) begin
                    hi_o   <= '0;
                    lo_o   <= '0;
                    div0_o <= 1'b1;
                end
            end
            if (state == RUN && !annul_i) begin
                acc <= step_acc;
                low <= step_low;
                cnt <= cnt - CW'(1);
            end
            if (last) begin
                hi_o   <= res_hi;
                lo_o   <= res_lo;
                div0_o <= 1'b0;
            end
        end
    end

endmodule
